lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_load_align.sv | 26 ++
 rtl/lsu.sv | 191 +++++++++++++++++++
 tb/tb_lsu.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } lsu_size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC0,
    ST_ACC1,
    ST_LWAIT,
    ST_RESP
  } lsu_state_e;

  // Byte-lane mask of an access before it is shifted to its offset.
  function automatic logic [3:0] size_mask(lsu_size_e sz);
    case (sz)
      SZ_BYTE: size_mask = 4'b0001;
      SZ_HALF: size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Number of bytes touched by an access.
  function automatic logic [2:0] size_nbytes(lsu_size_e sz);
    case (sz)
      SZ_BYTE: size_nbytes = 3'd1;
      SZ_HALF: size_nbytes = 3'd2;
      default: size_nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts and extends load data from the one or two RAM words of an access.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] beat0_i,
  input  logic [31:0] beat1_i,
  input  logic [1:0]  off_i,
  input  lsu_size_e   size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [63:0] shifted;

  // Shift the addressed byte to lane 0, then truncate and extend by size.
  always_comb begin
    shifted = {beat1_i, beat0_i} >> {off_i, 3'b000};
    data_o  = shifted[31:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      default: data_o = shifted[31:0];
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: splits unaligned accesses into up to two word beats on a
// synchronous one-cycle-latency RAM and returns extended load data.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          ram_we,
  output logic [3:0]    ram_be,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  lsu_state_e    state_q, state_d;
  logic          ram_we_q, ram_we_d;
  logic [3:0]    ram_be_q, ram_be_d;
  logic [AW-1:0] ram_waddr_q, ram_waddr_d;
  logic [AW-1:0] ram_raddr_q, ram_raddr_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;

  // Captured request fields.
  logic [AW-1:0] word0_q;
  logic          we_q, uns_q, split_q;
  lsu_size_e     size_q;
  logic [1:0]    off_q;
  logic [3:0]    be1_q;
  logic [31:0]   wd1_q;
  logic [31:0]   data0_q;

  // Incoming-request beat computation; the upper halves of the widened shifts
  // are exactly the beat-1 enables/data, so they are captured for later.
  lsu_size_e     size_in;
  logic [1:0]    off_in;
  logic [7:0]    be_wide;
  logic [63:0]   wd_wide;
  logic [AW-1:0] word0_in;
  logic          split_in;
  logic [AW-1:0] word1;
  logic          accept;
  logic [31:0]   ld_beat0, ld_beat1, ld_data;

  assign size_in  = lsu_size_e'(req_size);
  assign off_in   = req_addr[1:0];
  assign be_wide  = {4'b0000, size_mask(size_in)} << off_in;
  assign wd_wide  = {32'h0, req_wdata} << {off_in, 3'b000};
  assign word0_in = {req_addr[AW-1:2], 2'b00};
  assign split_in = ({1'b0, off_in} + size_nbytes(size_in)) > 3'd4;
  assign word1    = word0_q + {{(AW-3){1'b0}}, 3'd4};
  assign accept   = (state_q == ST_IDLE) && req_valid;

  assign ld_beat0 = split_q ? data0_q : ram_rdata;
  assign ld_beat1 = split_q ? ram_rdata : 32'h0;

  lsu_load_align u_load_align (
    .beat0_i    (ld_beat0),
    .beat1_i    (ld_beat1),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ld_data)
  );

  // Next state and next registered RAM/response outputs.
  always_comb begin
    state_d     = state_q;
    ram_we_d    = 1'b0;
    ram_be_d    = 4'b0000;
    ram_waddr_d = ram_waddr_q;
    ram_raddr_d = ram_raddr_q;
    ram_wdata_d = ram_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_ACC0;
          if (req_we) begin
            ram_we_d    = 1'b1;
            ram_be_d    = be_wide[3:0];
            ram_waddr_d = word0_in;
            ram_wdata_d = wd_wide[31:0];
          end else begin
            ram_raddr_d = word0_in;
          end
        end
      end
      ST_ACC0: begin
        if (split_q) begin
          state_d = ST_ACC1;
          if (we_q) begin
            ram_we_d    = 1'b1;
            ram_be_d    = be1_q;
            ram_waddr_d = word1;
            ram_wdata_d = wd1_q;
          end else begin
            ram_raddr_d = word1;
          end
        end else begin
          state_d     = we_q ? ST_RESP : ST_LWAIT;
          rsp_valid_d = we_q;
        end
      end
      ST_ACC1: begin
        state_d     = we_q ? ST_RESP : ST_LWAIT;
        rsp_valid_d = we_q;
      end
      ST_LWAIT: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ld_data;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ram_we_q    <= 1'b0;
      ram_be_q    <= '0;
      ram_waddr_q <= '0;
      ram_raddr_q <= '0;
      ram_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ram_we_q    <= ram_we_d;
      ram_be_q    <= ram_be_d;
      ram_waddr_q <= ram_waddr_d;
      ram_raddr_q <= ram_raddr_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Request capture on acceptance and beat-0 read data capture for split loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word0_q <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      split_q <= 1'b0;
      size_q  <= SZ_BYTE;
      off_q   <= '0;
      be1_q   <= '0;
      wd1_q   <= '0;
      data0_q <= '0;
    end else begin
      if (accept) begin
        word0_q <= word0_in;
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        split_q <= split_in;
        size_q  <= size_in;
        off_q   <= off_in;
        be1_q   <= be_wide[7:4];
        wd1_q   <= wd_wide[63:32];
      end
      if (state_q == ST_ACC1) data0_q <= ram_rdata;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_we    = ram_we_q;
  assign ram_be    = ram_be_q;
  assign ram_waddr = ram_waddr_q;
  assign ram_raddr = ram_raddr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a small behavioural RAM.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_waddr, ram_raddr, ram_wdata, ram_rdata;

  int checks = 0;
  int failures = 0;
  int be_viol = 0;

  logic [31:0] mem [16];
  logic [31:0] bw_addr [4];
  logic [3:0]  bw_be [4];
  logic [31:0] bw_wd [4];
  logic [31:0] cyc_raddr [21];
  int          nbeats;
  int          ready_bad;

  lsu #(.AW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .ram_we       (ram_we),
    .ram_be       (ram_be),
    .ram_waddr    (ram_waddr),
    .ram_raddr    (ram_raddr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  // 16-word RAM, byte-lane writes, registered read.
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_waddr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_raddr[5:2]];
  end

  always @(negedge clk)
    if (rst_n && !ram_we && ram_be != 4'b0000) be_viol++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One request; records write beats, per-cycle read address, latency, data.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata);
    nbeats = 0; ready_bad = 0; lat = -1; rdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      cyc_raddr[k] = ram_raddr;
      if (ram_we && nbeats < 4) begin
        bw_addr[nbeats] = ram_waddr; bw_be[nbeats] = ram_be; bw_wd[nbeats] = ram_wdata;
        nbeats++;
      end
      if (req_ready) ready_bad++;
      if (rsp_valid) begin
        lat = k - 1; rdata = rsp_rdata;
        break;
      end
    end
    check_eq("busy_ready", 64'(ready_bad), 64'd0);
    @(negedge clk);
    check_eq("rsp_pulse_end", {63'd0, rsp_valid}, 64'd0);
    check_eq("ready_after", {63'd0, req_ready}, 64'd1);
  endtask

  int          lat;
  logic [31:0] rd;
  logic [31:0] snap1, snap2;
  int          n_ready, n_rsp;
  logic [31:0] last_rsp;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    #2;
    check_eq("rst_ready", {63'd0, req_ready}, 64'd1);
    check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check_eq("rst_we", {63'd0, ram_we}, 64'd0);
    check_eq("rst_be", 64'(ram_be), 64'd0);
    check_eq("rst_waddr", 64'(ram_waddr), 64'd0);
    check_eq("rst_raddr", 64'(ram_raddr), 64'd0);
    check_eq("rst_wdata", 64'(ram_wdata), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Aligned word store, then signed byte load of the top byte.
    access(1'b1, 2'd2, 1'b0, 32'h0, 32'h12345678, lat, rd);
    check_eq("sw0_beats", 64'(nbeats), 64'd1);
    check_eq("sw0_waddr", 64'(bw_addr[0]), 64'h0);
    check_eq("sw0_be", 64'(bw_be[0]), 64'hF);
    check_eq("sw0_wdata", 64'(bw_wd[0]), 64'h12345678);
    check_eq("sw0_lat", 64'(lat), 64'd1);
    check_eq("sw0_rdata", 64'(rd), 64'd0);
    access(1'b0, 2'd0, 1'b0, 32'h3, 32'h0, lat, rd);
    check_eq("lb3_data", 64'(rd), 64'h12);
    check_eq("lb3_lat", 64'(lat), 64'd2);

    // Byte store into lane 1 and loads around it.
    access(1'b1, 2'd0, 1'b0, 32'h1, 32'h000000AB, lat, rd);
    check_eq("sb1_beats", 64'(nbeats), 64'd1);
    check_eq("sb1_be", 64'(bw_be[0]), 64'h2);
    check_eq("sb1_wdata", 64'(bw_wd[0]), 64'h0000AB00);
    access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, lat, rd);
    check_eq("lw0_data", 64'(rd), 64'h1234AB78);
    access(1'b0, 2'd0, 1'b0, 32'h1, 32'h0, lat, rd);
    check_eq("lb1_signed", 64'(rd), 64'hFFFFFFAB);
    access(1'b0, 2'd0, 1'b1, 32'h1, 32'h0, lat, rd);
    check_eq("lbu1_data", 64'(rd), 64'h000000AB);

    // Split word store and load.
    access(1'b1, 2'd2, 1'b0, 32'h5, 32'hDEADBEEF, lat, rd);
    check_eq("sw5_beats", 64'(nbeats), 64'd2);
    check_eq("sw5_b0_waddr", 64'(bw_addr[0]), 64'h4);
    check_eq("sw5_b0_be", 64'(bw_be[0]), 64'hE);
    check_eq("sw5_b0_wdata", 64'(bw_wd[0]), 64'hADBEEF00);
    check_eq("sw5_b1_waddr", 64'(bw_addr[1]), 64'h8);
    check_eq("sw5_b1_be", 64'(bw_be[1]), 64'h1);
    check_eq("sw5_b1_wdata", 64'(bw_wd[1]), 64'h000000DE);
    check_eq("sw5_lat", 64'(lat), 64'd2);
    access(1'b0, 2'd2, 1'b0, 32'h5, 32'h0, lat, rd);
    check_eq("lw5_data", 64'(rd), 64'hDEADBEEF);
    check_eq("lw5_lat", 64'(lat), 64'd3);

    // Split signed half load crossing words.
    access(1'b1, 2'd0, 1'b0, 32'h3, 32'h80, lat, rd);
    access(1'b1, 2'd0, 1'b0, 32'h4, 32'hFF, lat, rd);
    access(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, lat, rd);
    check_eq("lh3_data", 64'(rd), 64'hFFFFFF80);
    check_eq("lh3_lat", 64'(lat), 64'd3);

    // Half load at the top of the address space wraps to word 0.
    access(1'b1, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h5A, lat, rd);
    check_eq("sbtop_waddr", 64'(bw_addr[0]), 64'hFFFFFFFC);
    check_eq("sbtop_be", 64'(bw_be[0]), 64'h8);
    access(1'b0, 2'd1, 1'b1, 32'hFFFFFFFF, 32'h0, lat, rd);
    check_eq("lhtop_raddr0", 64'(cyc_raddr[1]), 64'hFFFFFFFC);
    check_eq("lhtop_raddr1", 64'(cyc_raddr[2]), 64'h0);
    check_eq("lhtop_data", 64'(rd), 64'h0000785A);

    // Reset during ACC0 of a split store.
    snap1 = mem[1]; snap2 = mem[2];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h6; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check_eq("abort_acc0_we", {63'd0, ram_we}, 64'd1);
    check_eq("abort_acc0_be", 64'(ram_be), 64'hC);
    rst_n = 1'b0;
    #1;
    check_eq("abort_we", {63'd0, ram_we}, 64'd0);
    check_eq("abort_be", 64'(ram_be), 64'd0);
    check_eq("abort_rsp", {63'd0, rsp_valid}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_ready", {63'd0, req_ready}, 64'd1);
    check_eq("abort_we_after", {63'd0, ram_we}, 64'd0);
    check_eq("abort_rsp_after", {63'd0, rsp_valid}, 64'd0);
    check_eq("abort_mem1", 64'(mem[1]), 64'(snap1));
    check_eq("abort_mem2", 64'(mem[2]), 64'(snap2));
    access(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, lat, rd);
    check_eq("post_abort_lw4", 64'(rd), 64'hADBEEFFF);
    check_eq("post_abort_lat", 64'(lat), 64'd2);

    // Back-to-back aligned loads with req_valid held high.
    n_ready = 0; n_rsp = 0; last_rsp = 32'h0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0;
    for (int k = 0; k < 12; k++) begin
      if (req_ready) n_ready++;
      if (rsp_valid) begin
        n_rsp++;
        last_rsp = rsp_rdata;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check_eq("b2b_ready_cycles", 64'(n_ready), 64'd3);
    check_eq("b2b_rsp_count", 64'(n_rsp), 64'd3);
    check_eq("b2b_rdata", 64'(last_rsp), 64'h8034AB78);

    repeat (2) @(negedge clk);
    check_eq("be_without_we", 64'(be_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
